// File: rtl/chess_pkg.sv
// chess_pkg: piece/colour encodings, sequencer state codes and the
// back-rank layout shared by game logic and the board write path.
package chess_pkg;

    localparam logic [2:0] PIECE_NONE   = 3'b000;
    localparam logic [2:0] PIECE_PAWN   = 3'b001;
    localparam logic [2:0] PIECE_KNIGHT = 3'b010;
    localparam logic [2:0] PIECE_BISHOP = 3'b011;
    localparam logic [2:0] PIECE_ROOK   = 3'b100;
    localparam logic [2:0] PIECE_QUEEN  = 3'b101;
    localparam logic [2:0] PIECE_KING   = 3'b110;

    localparam logic COLOR_WHITE = 1'b0;
    localparam logic COLOR_BLACK = 1'b1;

    typedef enum logic [1:0] {
        SEQ_IDLE   = 2'd0,
        SEQ_INIT   = 2'd1,
        SEQ_MV_SET = 2'd2,
        SEQ_MV_CLR = 2'd3
    } seq_state_t;

    // R N B Q K B N R from column 0
    function automatic logic [2:0] back_rank(input logic [2:0] col);
        logic [2:0] ty;
        case (col)
            3'd0, 3'd7: ty = PIECE_ROOK;
            3'd1, 3'd6: ty = PIECE_KNIGHT;
            3'd2, 3'd5: ty = PIECE_BISHOP;
            3'd3:       ty = PIECE_QUEEN;
            default:    ty = PIECE_KING;
        endcase
        return ty;
    endfunction

endpackage

// File: rtl/board_init_rom.sv
// board_init_rom: starting position lookup, square {row,col} -> piece.
// Row 0 is the black back rank, row 7 the white back rank.
module board_init_rom
    import chess_pkg::*;
(
    input  logic [5:0] addr,
    output logic [3:0] piece
);

    logic [2:0] row;
    logic [2:0] col;

    assign row = addr[5:3];
    assign col = addr[2:0];

    always_comb begin
        piece = {COLOR_WHITE, PIECE_NONE};
        unique case (1'b1)
            (row == 3'd0): piece = {COLOR_BLACK, back_rank(col)};
            (row == 3'd1): piece = {COLOR_BLACK, PIECE_PAWN};
            (row == 3'd6): piece = {COLOR_WHITE, PIECE_PAWN};
            (row == 3'd7): piece = {COLOR_WHITE, back_rank(col)};
            default:       piece = {COLOR_WHITE, PIECE_NONE};
        endcase
    end

endmodule

// File: rtl/board_write_sequencer.sv
// board_write_sequencer: single owner of the board-store write port.
// Define BOARD_WR_PROMO_EN to turn pawns reaching the last rank into queens.
module board_write_sequencer
    import chess_pkg::*;
#(
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       init_req,
    input  logic       mv_valid,
    output logic       mv_ready,
    input  logic [5:0] mv_from,
    input  logic [5:0] mv_to,
    input  logic [3:0] mv_piece,
    output logic       brd_wr_en,
    output logic [5:0] brd_wr_addr,
    output logic [3:0] brd_wr_data,
    output logic       busy,
    output logic       init_done,
    output logic [1:0] seq_state
);

    seq_state_t state_q, state_d;
    logic [6:0] cnt_q, cnt_d;
    logic       init_pend_q, init_pend_d;
    logic [5:0] from_q, from_d;
    logic [5:0] to_q, to_d;
    logic       wr_en_d;
    logic [5:0] wr_addr_d;
    logic [3:0] wr_data_d;
    logic       init_done_d;
    logic [5:0] rom_addr;
    logic [3:0] rom_piece;
    logic [3:0] set_piece;
    logic       accept;

    // ROM is indexed by the square the next INIT write targets
    assign rom_addr = (state_q == SEQ_INIT) ? cnt_q[5:0] + 6'd1 : 6'd0;

    board_init_rom u_rom (
        .addr  (rom_addr),
        .piece (rom_piece)
    );

`ifdef BOARD_WR_PROMO_EN
    logic last_rank;

    always_comb begin
        last_rank = (mv_piece[3] == COLOR_WHITE) ? (mv_to[5:3] == 3'd0)
                                                 : (mv_to[5:3] == 3'd7);
        set_piece = mv_piece;
        if (mv_piece[2:0] == PIECE_PAWN && last_rank)
            set_piece = {mv_piece[3], PIECE_QUEEN};
    end
`else
    assign set_piece = mv_piece;
`endif

    assign accept = mv_valid && mv_ready && !init_req && !init_pend_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_pend_d = init_pend_q;
        from_d      = from_q;
        to_d        = to_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = 6'd0;
        wr_data_d   = 4'd0;
        init_done_d = 1'b0;
        unique case (state_q)
            SEQ_IDLE: begin
                if (init_pend_q || init_req) begin
                    state_d   = SEQ_INIT;
                    cnt_d     = 7'd0;
                    wr_en_d   = 1'b1;
                    wr_addr_d = rom_addr;
                    wr_data_d = rom_piece;
                end else if (accept) begin
                    state_d   = SEQ_MV_SET;
                    from_d    = mv_from;
                    to_d      = mv_to;
                    wr_en_d   = 1'b1;
                    wr_addr_d = mv_to;
                    wr_data_d = set_piece;
                end
            end
            SEQ_INIT: begin
                if (cnt_q == 7'd63) begin
                    state_d     = SEQ_IDLE;
                    init_pend_d = 1'b0;
                    init_done_d = 1'b1;
                end else begin
                    cnt_d     = cnt_q + 7'd1;
                    wr_en_d   = 1'b1;
                    wr_addr_d = rom_addr;
                    wr_data_d = rom_piece;
                end
            end
            SEQ_MV_SET: begin
                if (init_req)
                    init_pend_d = 1'b1;
                if (from_q == to_q) begin
                    state_d = SEQ_IDLE;
                end else begin
                    state_d   = SEQ_MV_CLR;
                    wr_en_d   = 1'b1;
                    wr_addr_d = from_q;
                end
            end
            SEQ_MV_CLR: begin
                if (init_req)
                    init_pend_d = 1'b1;
                state_d = SEQ_IDLE;
            end
            default: state_d = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= SEQ_IDLE;
            cnt_q       <= 7'd0;
            init_pend_q <= INIT_ON_RESET;
            from_q      <= 6'd0;
            to_q        <= 6'd0;
            mv_ready    <= 1'b0;
            brd_wr_en   <= 1'b0;
            brd_wr_addr <= 6'd0;
            brd_wr_data <= 4'd0;
            busy        <= 1'b0;
            init_done   <= 1'b0;
            seq_state   <= 2'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_pend_q <= init_pend_d;
            from_q      <= from_d;
            to_q        <= to_d;
            mv_ready    <= (state_d == SEQ_IDLE) && !init_pend_d;
            brd_wr_en   <= wr_en_d;
            brd_wr_addr <= wr_addr_d;
            brd_wr_data <= wr_data_d;
            busy        <= (state_d != SEQ_IDLE) || init_pend_d;
            init_done   <= init_done_d;
            seq_state   <= state_d;
        end
    end

endmodule

// File: tb/tb_board_write_sequencer.sv
// tb_board_write_sequencer: randomized moves and init/reset scenarios
// checked against a board-level reference model.
`timescale 1ns/1ps
module tb_board_write_sequencer;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       init_req = 1'b0;
    logic       mv_valid = 1'b0;
    logic       mv_ready;
    logic [5:0] mv_from = 6'd0;
    logic [5:0] mv_to = 6'd0;
    logic [3:0] mv_piece = 4'd0;
    logic       brd_wr_en;
    logic [5:0] brd_wr_addr;
    logic [3:0] brd_wr_data;
    logic       busy;
    logic       init_done;
    logic [1:0] seq_state;

    board_write_sequencer #(.INIT_ON_RESET(1'b1)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .init_req    (init_req),
        .mv_valid    (mv_valid),
        .mv_ready    (mv_ready),
        .mv_from     (mv_from),
        .mv_to       (mv_to),
        .mv_piece    (mv_piece),
        .brd_wr_en   (brd_wr_en),
        .brd_wr_addr (brd_wr_addr),
        .brd_wr_data (brd_wr_data),
        .busy        (busy),
        .init_done   (init_done),
        .seq_state   (seq_state)
    );

    always #5 CLK = ~CLK;

`ifdef BOARD_WR_PROMO_EN
    localparam logic [3:0] PROMO_W = 4'b0101;
    localparam logic [3:0] PROMO_B = 4'b1101;
`else
    localparam logic [3:0] PROMO_W = 4'b0001;
    localparam logic [3:0] PROMO_B = 4'b1001;
`endif

    typedef struct packed {
        logic [5:0] a;
        logic [3:0] d;
    } wr_t;

    int checks = 0;
    int failures = 0;
    wr_t wq[$];
    logic [3:0] board[64];
    logic [3:0] mdl[64];

    always @(negedge CLK) begin
        if (brd_wr_en === 1'b1) begin
            wq.push_back(wr_t'{brd_wr_addr, brd_wr_data});
            board[brd_wr_addr] = brd_wr_data;
        end
    end

    function automatic logic [3:0] init_piece(int sq);
        int row = sq / 8;
        int col = sq % 8;
        int back[8] = '{4, 2, 3, 5, 6, 3, 2, 4};
        logic [2:0] ty;
        logic c;
        c = (row < 4);
        if (row == 0 || row == 7) ty = 3'(back[col]);
        else if (row == 1 || row == 6) ty = 3'd1;
        else return 4'b0000;
        return {c, ty};
    endfunction

    function automatic logic [3:0] promo(logic [3:0] p, logic [5:0] t);
`ifdef BOARD_WR_PROMO_EN
        int last = p[3] ? 7 : 0;
        if (p[2:0] == 3'd1 && int'(t[5:3]) == last) return {p[3], 3'd5};
`endif
        return p;
    endfunction

    function automatic void reset_model();
        for (int i = 0; i < 64; i++) mdl[i] = init_piece(i);
    endfunction

    function automatic int board_diff();
        int n = 0;
        for (int i = 0; i < 64; i++) if (board[i] !== mdl[i]) n++;
        return n;
    endfunction

    task automatic sample();
        @(negedge CLK);
        #1;
    endtask

    task automatic drive_edge();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_init_done(output int ok, output int early);
        ok = 0;
        early = 0;
        for (int n = 0; n < 300; n++) begin
            sample();
            if (init_done === 1'b1) begin
                ok = 1;
                break;
            end
            if (mv_ready === 1'b1) early = 1;
        end
    endtask

    task automatic check_init_seq(input string nm, input int base);
        int bad = 0;
        checks++;
        if (wq.size() != base + 64) begin
            failures++;
            $display("FAIL %s_count got=%0d want=%0d", nm, wq.size(), base + 64);
        end else begin
            for (int i = 0; i < 64; i++)
                if (wq[base + i] !== wr_t'{6'(i), init_piece(i)}) bad++;
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL %s_content bad_writes=%0d want=0", nm, bad);
            end
        end
    endtask

    task automatic send_move(input logic [5:0] f, input logic [5:0] t,
                             input logic [3:0] p, output int ok);
        drive_edge();
        mv_from = f;
        mv_to = t;
        mv_piece = p;
        mv_valid = 1'b1;
        ok = 0;
        for (int n = 0; n < 200; n++) begin
            sample();
            if (mv_ready === 1'b1) begin
                ok = 1;
                break;
            end
        end
        drive_edge();
        mv_valid = 1'b0;
    endtask

    task automatic check_move(input logic [5:0] f, input logic [5:0] t,
                              input logic [3:0] p, input string nm);
        wr_t exp[$];
        int ok;
        logic [3:0] put;
        put = promo(p, t);
        exp.push_back(wr_t'{t, put});
        if (f != t) exp.push_back(wr_t'{f, 4'b0000});
        send_move(f, t, p, ok);
        checks++;
        if (ok == 0) begin
            failures++;
            $display("FAIL %s_accept got=timeout want=mv_ready", nm);
            return;
        end
        foreach (exp[k]) begin
            sample();
            checks++;
            if ({brd_wr_en, brd_wr_addr, brd_wr_data, mv_ready} !==
                {1'b1, exp[k].a, exp[k].d, 1'b0}) begin
                failures++;
                $display("FAIL %s_wr%0d got en=%b a=%0d d=%b rdy=%b want en=1 a=%0d d=%b rdy=0",
                         nm, k, brd_wr_en, brd_wr_addr, brd_wr_data, mv_ready,
                         exp[k].a, exp[k].d);
            end
        end
        sample();
        checks++;
        if ({brd_wr_en, mv_ready} !== 2'b01) begin
            failures++;
            $display("FAIL %s_done got en=%b rdy=%b want en=0 rdy=1", nm, brd_wr_en, mv_ready);
        end
        mdl[t] = put;
        if (f != t) mdl[f] = 4'b0000;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        drive_edge();
        drive_edge();
        checks++;
        if ({brd_wr_en, brd_wr_addr, brd_wr_data, busy, init_done, seq_state, mv_ready} !== 16'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0000",
                     {brd_wr_en, brd_wr_addr, brd_wr_data, busy, init_done, seq_state, mv_ready});
        end
        wq.delete();
        RESET = 1'b0;
    endtask

    task automatic test_init_load();
        int ok, early;
        int idx[6] = '{0, 4, 9, 27, 60, 63};
        logic [3:0] want[6] = '{4'b1100, 4'b1110, 4'b1001, 4'b0000, 4'b0110, 4'b0100};
        wait_init_done(ok, early);
        checks++;
        if (ok == 0 || early != 0) begin
            failures++;
            $display("FAIL init_done got ok=%0d early_ready=%0d want ok=1 early_ready=0", ok, early);
        end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (wq.size() <= idx[k] || wq[idx[k]] !== wr_t'{6'(idx[k]), want[k]}) begin
                failures++;
                $display("FAIL init_addr%0d got=%h want a=%0d d=%b", idx[k],
                         (wq.size() > idx[k]) ? wq[idx[k]] : 10'h3ff, idx[k], want[k]);
            end
        end
        check_init_seq("init_load", 0);
        sample();
        checks++;
        if ({init_done, mv_ready, busy} !== 3'b010) begin
            failures++;
            $display("FAIL init_after got done=%b rdy=%b busy=%b want done=0 rdy=1 busy=0",
                     init_done, mv_ready, busy);
        end
        reset_model();
        checks++;
        if (board_diff() != 0) begin
            failures++;
            $display("FAIL init_board got=%0d_diffs want=0", board_diff());
        end
    endtask

    task automatic test_move_basic();
        check_move(6'd52, 6'd36, 4'b0001, "move_52_36");
        checks++;
        if ({board[36], board[52]} !== 8'b0001_0000) begin
            failures++;
            $display("FAIL move_board got=%b_%b want=0001_0000", board[36], board[52]);
        end
    endtask

    task automatic test_same_square();
        check_move(6'd12, 6'd12, 4'b1011, "same_sq");
    endtask

    task automatic test_promo();
        check_move(6'd8, 6'd0, 4'b0001, "promo_w");
        checks++;
        if (board[0] !== PROMO_W) begin
            failures++;
            $display("FAIL promo_w_data got=%b want=%b", board[0], PROMO_W);
        end
        check_move(6'd48, 6'd56, 4'b1001, "promo_b");
        checks++;
        if (board[56] !== PROMO_B) begin
            failures++;
            $display("FAIL promo_b_data got=%b want=%b", board[56], PROMO_B);
        end
        check_move(6'd9, 6'd63, 4'b0001, "no_promo");
        checks++;
        if (board[63] !== 4'b0001) begin
            failures++;
            $display("FAIL no_promo_data got=%b want=0001", board[63]);
        end
    endtask

    task automatic test_init_with_move();
        int ok, early;
        wq.delete();
        drive_edge();
        init_req = 1'b1;
        mv_valid = 1'b1;
        mv_from = 6'd12;
        mv_to = 6'd28;
        mv_piece = 4'b0001;
        drive_edge();
        init_req = 1'b0;
        wait_init_done(ok, early);
        checks++;
        if (ok == 0 || early != 0) begin
            failures++;
            $display("FAIL init_vs_move got ok=%0d early_ready=%0d want ok=1 early_ready=0", ok, early);
        end
        check_init_seq("init_vs_move", 0);
        drive_edge();
        mv_valid = 1'b0;
        sample();
        checks++;
        if ({brd_wr_en, brd_wr_addr, brd_wr_data} !== {1'b1, 6'd28, 4'b0001}) begin
            failures++;
            $display("FAIL held_move_set got en=%b a=%0d d=%b want en=1 a=28 d=0001",
                     brd_wr_en, brd_wr_addr, brd_wr_data);
        end
        sample();
        checks++;
        if ({brd_wr_en, brd_wr_addr, brd_wr_data} !== {1'b1, 6'd12, 4'b0000}) begin
            failures++;
            $display("FAIL held_move_clr got en=%b a=%0d d=%b want en=1 a=12 d=0000",
                     brd_wr_en, brd_wr_addr, brd_wr_data);
        end
        sample();
        reset_model();
        mdl[28] = 4'b0001;
        mdl[12] = 4'b0000;
        checks++;
        if (board_diff() != 0 || mv_ready !== 1'b1) begin
            failures++;
            $display("FAIL held_move_board got diffs=%0d rdy=%b want diffs=0 rdy=1",
                     board_diff(), mv_ready);
        end
    endtask

    task automatic test_init_req_during_move();
        int ok, early;
        wq.delete();
        send_move(6'd20, 6'd44, 4'b0011, ok);
        init_req = 1'b1;
        drive_edge();
        init_req = 1'b0;
        wait_init_done(ok, early);
        checks++;
        if (ok == 0 || early != 0) begin
            failures++;
            $display("FAIL move_then_init got ok=%0d early_ready=%0d want ok=1 early_ready=0", ok, early);
        end
        checks++;
        if (wq.size() < 2 || wq[0] !== wr_t'{6'd44, 4'b0011} || wq[1] !== wr_t'{6'd20, 4'b0000}) begin
            failures++;
            $display("FAIL move_then_init_order got size=%0d want move writes first", wq.size());
        end
        check_init_seq("move_then_init", 2);
        reset_model();
    endtask

    task automatic test_init_req_ignored();
        int ok, early;
        wq.delete();
        drive_edge();
        init_req = 1'b1;
        drive_edge();
        init_req = 1'b0;
        repeat (10) drive_edge();
        init_req = 1'b1;
        drive_edge();
        init_req = 1'b0;
        wait_init_done(ok, early);
        repeat (6) sample();
        checks++;
        if (ok == 0 || busy !== 1'b0 || mv_ready !== 1'b1) begin
            failures++;
            $display("FAIL init_ignore got ok=%0d busy=%b rdy=%b want ok=1 busy=0 rdy=1",
                     ok, busy, mv_ready);
        end
        check_init_seq("init_ignore", 0);
    endtask

    task automatic test_reset_mid_init();
        int ok, early, found;
        found = 0;
        drive_edge();
        init_req = 1'b1;
        drive_edge();
        init_req = 1'b0;
        for (int n = 0; n < 100; n++) begin
            sample();
            if (brd_wr_en === 1'b1 && brd_wr_addr === 6'd20) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (found == 0) begin
            failures++;
            $display("FAIL mid_init_reach got=timeout want=addr20");
        end
        RESET = 1'b1;
        #1;
        checks++;
        if ({brd_wr_en, brd_wr_addr, brd_wr_data, busy, init_done, seq_state, mv_ready} !== 16'd0) begin
            failures++;
            $display("FAIL mid_init_reset got=%h want=0000",
                     {brd_wr_en, brd_wr_addr, brd_wr_data, busy, init_done, seq_state, mv_ready});
        end
        drive_edge();
        drive_edge();
        wq.delete();
        RESET = 1'b0;
        wait_init_done(ok, early);
        checks++;
        if (ok == 0) begin
            failures++;
            $display("FAIL reinit_done got=timeout want=init_done");
        end
        check_init_seq("reinit", 0);
        reset_model();
        checks++;
        if (board_diff() != 0) begin
            failures++;
            $display("FAIL reinit_board got=%0d_diffs want=0", board_diff());
        end
    endtask

    task automatic test_random_moves();
        logic [5:0] f, t;
        logic [3:0] p;
        for (int i = 0; i < 40; i++) begin
            f = 6'($urandom_range(0, 63));
            t = ($urandom_range(0, 7) == 0) ? f : 6'($urandom_range(0, 63));
            p = 4'($urandom_range(0, 15));
            check_move(f, t, p, "rand");
        end
        checks++;
        if (board_diff() != 0) begin
            failures++;
            $display("FAIL rand_board got=%0d_diffs want=0", board_diff());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) board[i] = 4'hx;
        test_reset();
        test_init_load();
        test_move_basic();
        test_same_square();
        test_promo();
        test_init_with_move();
        test_init_req_during_move();
        test_init_req_ignored();
        test_reset_mid_init();
        test_random_moves();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
